// File: rtl/aes_seq_pkg.sv
// Shared widths, default geometry and counter sizing for the AES stream sequencer.
// Optional tag tracking is enabled with the AES_SEQ_TAG_EN macro.
package aes_seq_pkg;

  localparam int BLK_W       = 128;
  localparam int TAG_W       = 8;
  localparam int LATENCY_DEF = 11;
  localparam int DEPTH_DEF   = 16;

  // A counter that must represent 0..depth inclusive needs one value more than depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/aes_seq_fifo.sv
// First-word-fall-through FIFO holding captured ciphertext (and the tag when AES_SEQ_TAG_EN is defined).
// Pushes while full and pops while empty are ignored and flagged by assertions.
module aes_seq_fifo
  import aes_seq_pkg::*;
#(
  parameter int WIDTH = BLK_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int            CW   = cnt_w(DEPTH);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage is cleared so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/aes_stream_sequencer.sv
// Valid/ready streaming shell around the free-running, stall-free aes_128 pipeline.
// Define AES_SEQ_TAG_EN to carry an 8-bit tag per block and flag out-of-sequence tags.
module aes_stream_sequencer
  import aes_seq_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_state,
  input  logic [BLK_W-1:0] in_key,
  output logic [BLK_W-1:0] core_state,
  output logic [BLK_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data
`ifdef AES_SEQ_TAG_EN
  ,
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
  output logic             seq_err
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam int SW = CW + 1;
`ifdef AES_SEQ_TAG_EN
  localparam int FW = BLK_W + TAG_W;
`else
  localparam int FW = BLK_W;
`endif

  logic [LATENCY-1:0] r_vld_sr;
  logic [CW-1:0]      r_inflight;
  logic               r_in_ready;
  logic [CW-1:0]      w_inflight_nxt;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_count_nxt;
  logic [SW-1:0]      w_credit_nxt;
  logic               w_issue;
  logic               w_capture;
  logic               w_push_ok;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [FW-1:0]      w_fifo_din;
  logic [FW-1:0]      w_fifo_dout;

  assign w_issue    = in_valid & r_in_ready;
  assign w_capture  = r_vld_sr[LATENCY-1];
  assign w_push_ok  = w_capture & ~w_full;
  assign w_pop      = out_ready & ~w_empty;
  assign in_ready   = r_in_ready;
  assign out_valid  = ~w_empty;
  assign core_state = w_issue ? in_state : '0;
  assign core_key   = w_issue ? in_key : '0;

  // Next-state occupancy feeds the registered ready so out_ready never reaches in_ready combinationally.
  always_comb begin
    w_inflight_nxt = r_inflight;
    w_count_nxt    = w_count;
    case ({w_issue, w_capture})
      2'b10:   w_inflight_nxt = r_inflight + CW'(1);
      2'b01:   w_inflight_nxt = r_inflight - CW'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
    case ({w_push_ok, w_pop})
      2'b10:   w_count_nxt = w_count + CW'(1);
      2'b01:   w_count_nxt = w_count - CW'(1);
      default: w_count_nxt = w_count;
    endcase
    w_credit_nxt = SW'(w_inflight_nxt) + SW'(w_count_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr   <= '0;
      r_inflight <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_vld_sr[0] <= w_issue;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
      r_inflight <= w_inflight_nxt;
      r_in_ready <= (w_credit_nxt < SW'(DEPTH));
    end
  end

`ifdef AES_SEQ_TAG_EN
  logic [TAG_W-1:0] r_tag_sr [LATENCY];
  logic [TAG_W-1:0] r_last_tag;
  logic             r_tag_primed;
  logic             r_seq_err;
  logic [TAG_W-1:0] w_cap_tag;

  assign w_cap_tag  = r_tag_sr[LATENCY-1];
  assign w_fifo_din = {w_cap_tag, core_out};
  assign out_data   = w_fifo_dout[BLK_W-1:0];
  assign out_tag    = w_fifo_dout[FW-1:BLK_W];
  assign seq_err    = r_seq_err;

  // The first capture after reset only seeds the reference; later captures must step by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_sr[i] <= '0;
      end
      r_last_tag   <= '0;
      r_tag_primed <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_tag_sr[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_sr[i] <= r_tag_sr[i-1];
      end
      if (w_capture) begin
        r_last_tag   <= w_cap_tag;
        r_tag_primed <= 1'b1;
        if (r_tag_primed && (w_cap_tag != r_last_tag + TAG_W'(1))) begin
          r_seq_err <= 1'b1;
        end
      end
    end
  end
`else
  assign w_fifo_din = core_out;
  assign out_data   = w_fifo_dout;
`endif

  aes_seq_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_capture),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    (SW'(r_inflight) + SW'(w_count)) <= SW'(DEPTH));

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// Bench for aes_stream_sequencer with a stand-in aes_128 pipeline and an in-order scoreboard.
// Tag checks are compiled in when AES_SEQ_TAG_EN is defined.
module tb_aes_stream_sequencer;

  localparam int LAT = 11;
  localparam int DEP = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
`ifdef AES_SEQ_TAG_EN
  logic [7:0]   in_tag = '0;
  logic [7:0]   out_tag;
  logic         seq_err;
  logic [7:0]   exp_tag_q[$];
  logic [7:0]   got_tag_q[$];
`endif

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  bit           last_acc = 1'b0;
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  int           pop_cyc[$];
  logic [127:0] core_pipe [LAT];

  always #5 clk = ~clk;

  aes_stream_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .in_key     (in_key),
    .core_state (core_state),
    .core_key   (core_key),
    .core_out   (core_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef AES_SEQ_TAG_EN
    ,
    .in_tag     (in_tag),
    .out_tag    (out_tag),
    .seq_err    (seq_err)
`endif
  );

  // Stand-in for aes_128: real FIPS-197 answer for the reference pair, a keyed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ {k[63:0], k[127:64]} ^ 128'ha5a5_0f0f_3c3c_c3c3_5a5a_f0f0_1234_8765;
  endfunction

  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_state, core_key);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  // One clock: record accepted blocks as expectations and popped words as observations.
  task automatic tick();
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      exp_q.push_back(core_fn(in_state, in_key));
`ifdef AES_SEQ_TAG_EN
      exp_tag_q.push_back(in_tag);
`endif
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      pop_cyc.push_back(cyc);
`ifdef AES_SEQ_TAG_EN
      got_tag_q.push_back(out_tag);
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    pop_cyc.delete();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_state = FIPS_PT;
    in_key = FIPS_KEY;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("[TB] FAIL reset_out_data: got=%h want=0", out_data); end
    total++; if (core_state !== '0 || core_key !== '0) begin bad++; $display("[TB] FAIL reset_core_in: got=%h/%h want=0", core_state, core_key); end
`ifdef AES_SEQ_TAG_EN
    total++; if (seq_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_seq_err: got=%b want=0", seq_err); end
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready: got=%b want=1", in_ready); end
  endtask

  task automatic test_fips();
    int n;
    logic [127:0] g;
    logic [127:0] e;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_state = FIPS_PT;
    in_key = FIPS_KEY;
    #1;
    total++; if (core_state !== FIPS_PT || core_key !== FIPS_KEY) begin bad++; $display("[TB] FAIL fips_core_drive: got=%h/%h want=%h/%h", core_state, core_key, FIPS_PT, FIPS_KEY); end
    tick();
    in_valid = 1'b0;
    total++; if (!last_acc) begin bad++; $display("[TB] FAIL fips_accept: got=0 want=1"); end
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    total++; if (n !== LAT + 1) begin bad++; $display("[TB] FAIL fips_latency: got=%0d want=%0d", n, LAT + 1); end
    total++; if (out_data !== FIPS_CT) begin bad++; $display("[TB] FAIL fips_data: got=%h want=%h", out_data, FIPS_CT); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (got_q.size() != 1 || exp_q.size() != 1) begin bad++; $display("[TB] FAIL fips_count: got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("[TB] FAIL fips_pop: got=%h want=%h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    int stalls;
    logic [127:0] g;
    logic [127:0] e;
    stalls = 0;
    pop_cyc.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_state = {4{32'(i) ^ 32'h1357_0000}};
      in_key = {4{32'(i * 7 + 1)}};
      if (!in_ready) stalls++;
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 6) tick();
    total++; if (stalls != 0) begin bad++; $display("[TB] FAIL b2b_in_ready: got=%0d stalls want=0", stalls); end
    total++; if (got_q.size() != 32) begin bad++; $display("[TB] FAIL b2b_count: got=%0d want=32", got_q.size()); end
    total++; if (pop_cyc.size() < 32 || pop_cyc[31] - pop_cyc[0] != 31) begin bad++; $display("[TB] FAIL b2b_rate: got=%0d pops want=32 in 32 cycles", pop_cyc.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL b2b_extra: got=%h want=none", g); end
      else begin
        e = exp_q.pop_front();
        if (g !== e) begin bad++; $display("[TB] FAIL b2b_order: got=%h want=%h", g, e); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int acc;
    logic [127:0] g;
    logic [127:0] e;
    acc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_state = {96'hbeef_0000_cafe_0000_d00d_0000, 32'(acc)};
    in_key = ~in_state;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (last_acc) begin
        acc++;
        in_state = {96'hbeef_0000_cafe_0000_d00d_0000, 32'(acc)};
        in_key = ~in_state;
      end
    end
    total++; if (acc != DEP) begin bad++; $display("[TB] FAIL bp_accepts: got=%0d want=%0d", acc, DEP); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready: got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_out_valid: got=%b want=1", out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (acc >= 20) in_valid = 1'b0;
      tick();
      if (last_acc) begin
        acc++;
        in_state = {96'hbeef_0000_cafe_0000_d00d_0000, 32'(acc)};
        in_key = ~in_state;
      end
    end
    in_valid = 1'b0;
    total++; if (acc != 20) begin bad++; $display("[TB] FAIL bp_total_accepts: got=%0d want=20", acc); end
    total++; if (got_q.size() != 20) begin bad++; $display("[TB] FAIL bp_outputs: got=%0d want=20", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL bp_extra: got=%h want=none", g); end
      else begin
        e = exp_q.pop_front();
        if (g !== e) begin bad++; $display("[TB] FAIL bp_order: got=%h want=%h", g, e); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random_bubbles();
    int acc;
    int c;
    logic [127:0] g;
    logic [127:0] e;
    acc = 0;
    c = 0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key = {$urandom, $urandom, $urandom, $urandom};
    while (acc < 1000 && c < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      c++;
      if (last_acc) begin
        acc++;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_key = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + DEP + 4) tick();
    total++; if (acc != 1000) begin bad++; $display("[TB] FAIL rnd_accepts: got=%0d want=1000", acc); end
    total++; if (got_q.size() != 1000) begin bad++; $display("[TB] FAIL rnd_outputs: got=%0d want=1000", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL rnd_extra: got=%h want=none", g); end
      else begin
        e = exp_q.pop_front();
        if (g !== e) begin bad++; $display("[TB] FAIL rnd_order: got=%h want=%h", g, e); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 2) tick();
    in_valid = 1'b1;
    repeat (5) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || exp_q.size() != 8) begin bad++; $display("[TB] FAIL mid_setup: got=%b/%0d want=1/8", out_valid, exp_q.size()); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid: got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_in_ready: got=%b want=0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b1;
    repeat (30) tick();
    total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL mid_stale: got=%0d outputs want=0", got_q.size()); end
    got_q.delete();
    test_fips();
  endtask

`ifdef AES_SEQ_TAG_EN
  task automatic test_tags();
    logic [7:0] g;
    logic [7:0] e;
    logic [7:0] skip_seq [10];
    pulse_reset();
    exp_tag_q.delete();
    got_tag_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i <= 300; i++) begin
      in_tag = 8'(i);
      in_state = {4{32'(i)}};
      in_key = {4{32'(i + 99)}};
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 6) tick();
    total++; if (got_tag_q.size() != 301) begin bad++; $display("[TB] FAIL tag_count: got=%0d want=301", got_tag_q.size()); end
    while (got_tag_q.size() > 0 && exp_tag_q.size() > 0) begin
      g = got_tag_q.pop_front();
      e = exp_tag_q.pop_front();
      total++; if (g !== e) begin bad++; $display("[TB] FAIL tag_order: got=%0d want=%0d", g, e); end
    end
    total++; if (seq_err !== 1'b0) begin bad++; $display("[TB] FAIL tag_seq_err_clean: got=%b want=0", seq_err); end
    skip_seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    pulse_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_tag = skip_seq[i];
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 4) tick();
    total++; if (seq_err !== 1'b1) begin bad++; $display("[TB] FAIL tag_skip_detect: got=%b want=1", seq_err); end
    repeat (20) tick();
    total++; if (seq_err !== 1'b1) begin bad++; $display("[TB] FAIL tag_skip_sticky: got=%b want=1", seq_err); end
    in_tag = '0;
  endtask
`endif

  initial begin
    for (int i = 0; i < LAT; i++) core_pipe[i] = '0;
    test_reset();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_random_bubbles();
    test_reset_midflight();
`ifdef AES_SEQ_TAG_EN
    test_tags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got=timeout want=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
